// File: rtl/clk_reset_pkg.sv
// Shared state type and counter-width helpers for the clock/reset generator.
package clk_reset_pkg;

    typedef enum logic {
        HOLD = 1'b0,
        RUN  = 1'b1
    } rst_state_t;

    function automatic int cnt_width(input int unsigned cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int DEB_W(input int unsigned cycles);
        return cnt_width(cycles);
    endfunction

    function automatic int HOLD_W(input int unsigned cycles);
        return cnt_width(cycles);
    endfunction

    function automatic int WDT_W(input int unsigned cycles);
        return cnt_width(cycles);
    endfunction

endpackage

// File: rtl/clk_reset_gen_btn_debounce.sv
// Synchronises the raw active-low button and accepts a level only after it
// has been stable for DEBOUNCE_CYCLES CLK cycles.
module btn_debounce
    import clk_reset_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 65536
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic BTN_N,
    output logic stable_n
);

    localparam int DW = DEB_W(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 32'd1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic [DW-1:0] cnt_q, cnt_d;

    // Next-state: synchroniser shift and stability counter.
    always_comb begin
        sync1_d  = BTN_N;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = {DW{1'b0}};
        if (sync2_q == stable_q) begin
            cnt_d = {DW{1'b0}};
        end else if (cnt_q == DEB_LAST) begin
            stable_d = sync2_q;
            cnt_d    = {DW{1'b0}};
        end else begin
            cnt_d = cnt_q + DW'(1'b1);
        end
    end

    // State registers; reset assumes the button is released.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= {DW{1'b0}};
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_n = stable_q;

endmodule

// File: rtl/clk_reset_gen.sv
// Board clock/reset generator: CLK divider, debounced button, reset sequencer.
// Optional watchdog is built when CLK_RESET_GEN_WDT_EN is defined.
module clk_reset_gen
    import clk_reset_pkg::*;
#(
    parameter int unsigned DIV_LOG2        = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 65536,
    parameter int unsigned RESET_HOLD      = 16,
    parameter int unsigned WDT_CYCLES      = 32'd1 << 20
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic BTN_N,
    input  logic wdt_kick,
    output logic clk,
    output logic clk_en,
    output logic power_on_reset,
    output logic wdt_fired
);

    localparam int HW = HOLD_W(RESET_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 32'd1);

    logic [DIV_LOG2-1:0] div_cnt_q, div_cnt_d;
    rst_state_t          state_q, state_d;
    logic [HW-1:0]       hold_cnt_q, hold_cnt_d;
    logic                por_q, por_d;
    logic                btn_stable_n_s;
    logic                btn_pressed_s;
    logic                wdt_expire_s;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .BTN_N    (BTN_N),
        .stable_n (btn_stable_n_s)
    );

    assign btn_pressed_s = ~btn_stable_n_s;
    assign clk           = div_cnt_q[DIV_LOG2-1];
    assign clk_en        = &div_cnt_q;

`ifdef CLK_RESET_GEN_WDT_EN
    localparam int WW = WDT_W(WDT_CYCLES);
    localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES - 32'd1);

    logic [WW-1:0] wdt_cnt_q, wdt_cnt_d;
    logic          wdt_fired_q, wdt_fired_d;

    // Watchdog: counts clk periods in RUN, a kick restarts it; button beats expiry.
    always_comb begin
        wdt_cnt_d    = wdt_cnt_q;
        wdt_fired_d  = wdt_fired_q;
        wdt_expire_s = 1'b0;
        if (clk_en && (state_q == RUN)) begin
            if (wdt_kick) begin
                wdt_cnt_d = {WW{1'b0}};
            end else if (wdt_cnt_q == WDT_LAST) begin
                wdt_cnt_d    = {WW{1'b0}};
                wdt_expire_s = 1'b1;
            end else begin
                wdt_cnt_d = wdt_cnt_q + WW'(1'b1);
            end
            if (btn_pressed_s) begin
                wdt_fired_d = 1'b0;
            end else if (wdt_expire_s) begin
                wdt_fired_d = 1'b1;
            end else begin
                wdt_fired_d = wdt_fired_q;
            end
        end else if (clk_en) begin
            wdt_cnt_d = {WW{1'b0}};
        end else begin
            wdt_cnt_d = wdt_cnt_q;
        end
    end

    assign wdt_fired = wdt_fired_q;
`else
    logic wdt_unused_s;

    assign wdt_expire_s = 1'b0;
    assign wdt_fired    = 1'b0;
    assign wdt_unused_s = wdt_kick & (WDT_CYCLES != 32'd0);
`endif

    // Divider and sequencer next-state; the sequencer moves only on clk_en.
    always_comb begin
        div_cnt_d  = div_cnt_q + DIV_LOG2'(1'b1);
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        if (clk_en) begin
            case (state_q)
                HOLD: begin
                    if (btn_pressed_s) begin
                        hold_cnt_d = {HW{1'b0}};
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        state_d    = RUN;
                        hold_cnt_d = {HW{1'b0}};
                    end else begin
                        hold_cnt_d = hold_cnt_q + HW'(1'b1);
                    end
                end
                RUN: begin
                    if (btn_pressed_s || wdt_expire_s) begin
                        state_d    = HOLD;
                        hold_cnt_d = {HW{1'b0}};
                    end else begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d    = HOLD;
                    hold_cnt_d = {HW{1'b0}};
                end
            endcase
        end else begin
            state_d = state_q;
        end
        // Registered from the next state so deassertion lands on the clk fall.
        por_d = (state_d != RUN);
    end

    // All generator state; RST_N forces HOLD with reset asserted.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            div_cnt_q   <= {DIV_LOG2{1'b0}};
            state_q     <= HOLD;
            hold_cnt_q  <= {HW{1'b0}};
            por_q       <= 1'b1;
`ifdef CLK_RESET_GEN_WDT_EN
            wdt_cnt_q   <= {WW{1'b0}};
            wdt_fired_q <= 1'b0;
`endif
        end else begin
            div_cnt_q   <= div_cnt_d;
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            por_q       <= por_d;
`ifdef CLK_RESET_GEN_WDT_EN
            wdt_cnt_q   <= wdt_cnt_d;
            wdt_fired_q <= wdt_fired_d;
`endif
        end
    end

    assign power_on_reset = por_q;

endmodule

// File: tb/tb_clk_reset_gen.sv
// Bench for clk_reset_gen: event-level reference model checked every CLK,
// a table of phases with end-state expectations, and corner-case sequences.
module tb_clk_reset_gen;

    localparam int R = 4;
    localparam int D = 8;
    localparam int H = 16;
    localparam int W = 32;
`ifdef CLK_RESET_GEN_WDT_EN
    localparam bit WDT_ON = 1'b1;
`else
    localparam bit WDT_ON = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST_N;
    logic BTN_N;
    logic wdt_kick;
    logic clk, clk_en, power_on_reset, wdt_fired;

    clk_reset_gen #(
        .DIV_LOG2        (2),
        .DEBOUNCE_CYCLES (D),
        .RESET_HOLD      (H),
        .WDT_CYCLES      (W)
    ) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .BTN_N          (BTN_N),
        .wdt_kick       (wdt_kick),
        .clk            (clk),
        .clk_en         (clk_en),
        .power_on_reset (power_on_reset),
        .wdt_fired      (wdt_fired)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: elapsed CLKs, debounce history, event counters.
    int m_cyc;
    bit m_stable;
    int m_deb_run;
    bit bq[$];
    bit m_run;
    int m_hold;
    int m_since;
    bit m_fired;

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cyc     = 0;
        m_stable  = 1'b1;
        m_deb_run = 0;
        bq        = '{1'b1, 1'b1};
        m_run     = 1'b0;
        m_hold    = 0;
        m_since   = 0;
        m_fired   = 1'b0;
    endtask

    task automatic model_step();
        bit en, pressed, synced, expire;
        en      = ((m_cyc % R) == R - 1);
        pressed = !m_stable;
        synced  = bq[0];
        expire  = 1'b0;
        if (en) begin
            if (!m_run) begin
                if (pressed) begin
                    m_hold = 0;
                end else begin
                    m_hold++;
                    if (m_hold == H) begin
                        m_run   = 1'b1;
                        m_hold  = 0;
                        m_since = 0;
                    end
                end
            end else begin
                if (WDT_ON) begin
                    if (wdt_kick) m_since = 0;
                    else begin
                        m_since++;
                        if (m_since == W) expire = 1'b1;
                    end
                end
                if (pressed) begin
                    m_run = 1'b0; m_hold = 0; m_fired = 1'b0;
                end else if (expire) begin
                    m_run = 1'b0; m_hold = 0; m_fired = 1'b1;
                end
            end
        end
        if (synced == m_stable) m_deb_run = 0;
        else begin
            m_deb_run++;
            if (m_deb_run == D) begin
                m_stable  = synced;
                m_deb_run = 0;
            end
        end
        void'(bq.pop_front());
        bq.push_back(BTN_N);
        m_cyc++;
    endtask

    task automatic tick();
        @(posedge CLK);
        if (!RST_N) model_reset();
        else model_step();
        #1;
        check("model clk", clk, ((m_cyc % R) >= R / 2));
        check("model clk_en", clk_en, ((m_cyc % R) == R - 1));
        check("model power_on_reset", power_on_reset, !m_run);
        check("model wdt_fired", wdt_fired, m_fired);
    endtask

    typedef struct {
        logic btn_n;
        logic kick;
        int   len;
        logic exp_por;
        logic exp_fired;
    } vec_t;

    vec_t tbl[11];
    logic clk_phase[4];
    logic was_en, got, lvl;
    int   n, cnt, len, kick_left;

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 200, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 5,   1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 40,  1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 20,  1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 40,  1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 60,  1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 100, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 150, WDT_ON, WDT_ON};
        tbl[8]  = '{1'b1, 1'b1, 200, 1'b0, WDT_ON};
        tbl[9]  = '{1'b0, 1'b1, 20,  1'b1, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 120, 1'b0, 1'b0};
        clk_phase = '{1'b0, 1'b0, 1'b1, 1'b1};

        RST_N = 1'b1; BTN_N = 1'b1; wdt_kick = 1'b0;
        #3 RST_N = 1'b0;
        #1;
        check("reset clk", clk, 1'b0);
        check("reset clk_en", clk_en, 1'b0);
        check("reset por", power_on_reset, 1'b1);
        check("reset wdt_fired", wdt_fired, 1'b0);
        model_reset();
        repeat (3) tick();
        RST_N = 1'b1;

        // Release: 4-CLK clk period, reset drops on 16th clk_en with clk falling.
        for (int e = 1; e <= 64; e++) begin
            tick();
            if (e <= 8) check($sformatf("clk phase e%0d", e), clk, clk_phase[e % 4]);
            if (e == 63) begin
                check("por before 16th clk_en", power_on_reset, 1'b1);
                check("clk high before drop", clk, 1'b1);
            end
            if (e == 64) begin
                check("por at 16th clk_en", power_on_reset, 1'b0);
                check("clk falls at drop", clk, 1'b0);
            end
        end

        for (int v = 0; v < 11; v++) begin
            for (int i = 0; i < tbl[v].len; i++) begin
                BTN_N    = tbl[v].btn_n;
                wdt_kick = tbl[v].kick && ((i % 80) < 4);
                tick();
            end
            check($sformatf("vec%0d por", v), power_on_reset, tbl[v].exp_por);
            check($sformatf("vec%0d wdt_fired", v), wdt_fired, tbl[v].exp_fired);
        end
        wdt_kick = 1'b0;

`ifdef CLK_RESET_GEN_WDT_EN
        // Last kick, then expiry on the 32nd clk_en.
        wdt_kick = 1'b1; was_en = 1'b0; n = 0;
        while (!was_en && n < 8) begin was_en = clk_en; tick(); n++; end
        wdt_kick = 1'b0;
        cnt = 0; n = 0; got = 1'b0;
        while (!got && n < 400) begin
            was_en = clk_en; tick(); n++;
            if (was_en) cnt++;
            if (power_on_reset) got = 1'b1;
        end
        check_int("wdt expiry clk_en count", cnt, 32);
        check("wdt fired after expiry", wdt_fired, 1'b1);
`endif

        // Asynchronous reset between edges, then the full hold sequence again.
        #2 RST_N = 1'b0;
        #1;
        check("async rst por", power_on_reset, 1'b1);
        check("async rst clk", clk, 1'b0);
        check("async rst wdt_fired", wdt_fired, 1'b0);
        repeat (2) tick();
        RST_N = 1'b1;
        n = 0; got = 1'b0;
        while (!got && n < 200) begin
            tick(); n++;
            if (!power_on_reset) got = 1'b1;
        end
        check_int("rehold CLK count", n, 64);

        // Button press lands on the same clk_en as the watchdog expiry.
        wdt_kick = 1'b1; was_en = 1'b0; n = 0;
        while (!was_en && n < 8) begin was_en = clk_en; tick(); n++; end
        wdt_kick = 1'b0;
        cnt = 0; n = 0; got = 1'b0;
        while (!got && n < 400) begin
            was_en = clk_en; tick(); n++;
            if (was_en) begin
                cnt++;
                if (cnt == 29) BTN_N = 1'b0;
            end
            if (power_on_reset) got = 1'b1;
        end
        check_int("same-edge clk_en count", cnt, 32);
        check("same-edge wdt_fired", wdt_fired, 1'b0);
        BTN_N = 1'b1;
        repeat (120) tick();
        check("recover after same-edge", power_on_reset, 1'b0);

        // Random button bursts and sporadic kicks against the model.
        kick_left = 0;
        for (int seg = 0; seg < 120; seg++) begin
            lvl = ($urandom_range(0, 3) != 0);
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) begin
                BTN_N = lvl;
                if (kick_left > 0) begin
                    wdt_kick = 1'b1;
                    kick_left--;
                end else begin
                    wdt_kick = 1'b0;
                    if ($urandom_range(0, 40) == 0) kick_left = 4;
                end
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
